// File: rtl/axi_lite_master_bridge_pkg.sv
// ============================================================================
// Package     : AxiMasterPkg
// Description : Shared FSM state encoding and AXI response codes for the
//               AXI-Lite master bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package AxiMasterPkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        READ  = 3'd3,
        RRESP = 3'd4,
        DONE  = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_lite_master_bridge_if.sv
// ============================================================================
// Interface   : AXI_ift
// Description : AXI4-Lite AW/W/B/AR/R channel bundle with master and slave
//               views.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface AXI_ift #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport Master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport Slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

`default_nettype wire

// File: rtl/axi_lite_master_bridge.sv
// ============================================================================
// Module      : axi_lite_master_bridge
// Description : Converts a held read/write request into one AXI4-Lite
//               transaction and reports completion with a one-cycle pulse.
//               Optional macro AXI_MASTER_DEBUG_EN adds state/count debug ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_master_bridge
    import AxiMasterPkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 64,
    parameter int C_M_AXI_ADDR_WIDTH = 64
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_i,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_i,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] wmask_i,
    input  logic                            ren_i,
    input  logic                            wen_i,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_o,
    output logic                            valid_o,
    output logic                            resp_err_o,
`ifdef AXI_MASTER_DEBUG_EN
    output logic [2:0]                      debug_state_o,
    output logic [31:0]                     debug_txn_cnt_o,
`endif
    AXI_ift.Master                          master_ift
);

    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

    state_e                          state_q,    state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q,     addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q,    wdata_d;
    logic [STRB_W-1:0]               wmask_q,    wmask_d;
    logic                            awvalid_q,  awvalid_d;
    logic                            wvalid_q,   wvalid_d;
    logic                            bready_q,   bready_d;
    logic                            arvalid_q,  arvalid_d;
    logic                            rready_q,   rready_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q,    rdata_d;
    logic                            resp_err_q, resp_err_d;
    logic                            valid_q,    valid_d;
    logic                            aw_done,    w_done;
`ifdef AXI_MASTER_DEBUG_EN
    logic [31:0]                     txn_cnt_q,  txn_cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        rdata_d    = rdata_q;
        resp_err_d = resp_err_q;
        valid_d    = 1'b0;
        aw_done    = 1'b0;
        w_done     = 1'b0;

        case (state_q)
            IDLE: begin
                // A simultaneous read is dropped: write has priority.
                if (wen_i) begin
                    addr_d    = addr_i;
                    wdata_d   = wdata_i;
                    wmask_d   = wmask_i;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = WRITE;
                end else if (ren_i) begin
                    addr_d    = addr_i;
                    arvalid_d = 1'b1;
                    state_d   = READ;
                end
            end
            WRITE: begin
                aw_done = !awvalid_q || master_ift.awready;
                w_done  = !wvalid_q  || master_ift.wready;
                if (master_ift.awready) awvalid_d = 1'b0;
                if (master_ift.wready)  wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = WRESP;
                end
            end
            WRESP: begin
                if (master_ift.bvalid) begin
                    bready_d   = 1'b0;
                    resp_err_d = resp_is_err(master_ift.bresp);
                    valid_d    = 1'b1;
                    state_d    = DONE;
                end
            end
            READ: begin
                if (master_ift.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RRESP;
                end
            end
            RRESP: begin
                if (master_ift.rvalid) begin
                    rready_d   = 1'b0;
                    rdata_d    = master_ift.rdata;
                    resp_err_d = resp_is_err(master_ift.rresp);
                    valid_d    = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef AXI_MASTER_DEBUG_EN
        txn_cnt_d = txn_cnt_q + {31'd0, valid_d};
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            rdata_q    <= '0;
            resp_err_q <= 1'b0;
            valid_q    <= 1'b0;
`ifdef AXI_MASTER_DEBUG_EN
            txn_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            rdata_q    <= rdata_d;
            resp_err_q <= resp_err_d;
            valid_q    <= valid_d;
`ifdef AXI_MASTER_DEBUG_EN
            txn_cnt_q  <= txn_cnt_d;
`endif
        end
    end

    assign master_ift.awaddr  = addr_q;
    assign master_ift.awprot  = 3'b000;
    assign master_ift.awvalid = awvalid_q;
    assign master_ift.wdata   = wdata_q;
    assign master_ift.wstrb   = wmask_q;
    assign master_ift.wvalid  = wvalid_q;
    assign master_ift.bready  = bready_q;
    assign master_ift.araddr  = addr_q;
    assign master_ift.arprot  = 3'b000;
    assign master_ift.arvalid = arvalid_q;
    assign master_ift.rready  = rready_q;

    assign rdata_o    = rdata_q;
    assign valid_o    = valid_q;
    assign resp_err_o = resp_err_q;

`ifdef AXI_MASTER_DEBUG_EN
    assign debug_state_o   = state_q;
    assign debug_txn_cnt_o = txn_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_master_bridge.sv
// ============================================================================
// Module      : tb_axi_lite_master_bridge
// Description : Self-checking bench for axi_lite_master_bridge with an AXI
//               slave model, directed vectors and randomized transactions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_lite_master_bridge;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] wdata_i;
    logic [SW-1:0] wmask_i;
    logic          ren_i, wen_i;
    logic [DW-1:0] rdata_o;
    logic          valid_o, resp_err_o;
`ifdef AXI_MASTER_DEBUG_EN
    logic [2:0]    debug_state;
    logic [31:0]   debug_cnt;
`endif

    always #5 clk = ~clk;

    AXI_ift #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axi_lite_master_bridge #(
        .C_M_AXI_DATA_WIDTH(DW),
        .C_M_AXI_ADDR_WIDTH(AW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .wmask_i    (wmask_i),
        .ren_i      (ren_i),
        .wen_i      (wen_i),
        .rdata_o    (rdata_o),
        .valid_o    (valid_o),
        .resp_err_o (resp_err_o),
`ifdef AXI_MASTER_DEBUG_EN
        .debug_state_o   (debug_state),
        .debug_txn_cnt_o (debug_cnt),
`endif
        .master_ift (axi)
    );

    // ---------------- slave model ----------------
    bit rand_mode = 1'b0;
    bit force_aw = 1'b1, force_w = 1'b1, force_ar = 1'b1;
    bit rnd_aw = 1'b0, rnd_w = 1'b0, rnd_ar = 1'b0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [63:0] cfg_rdata = 64'h0;
    int          cfg_bdly = 0, cfg_rdly = 0;

    always @(posedge clk) begin
        rnd_aw <= 1'($urandom % 2);
        rnd_w  <= 1'($urandom % 2);
        rnd_ar <= 1'($urandom % 2);
    end

    assign axi.awready = rand_mode ? rnd_aw : force_aw;
    assign axi.wready  = rand_mode ? rnd_w  : force_w;
    assign axi.arready = rand_mode ? rnd_ar : force_ar;

    logic aw_got, w_got, b_pend, r_pend;
    int   b_tmr, r_tmr;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            b_tmr <= 0; r_tmr <= 0;
            axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
            axi.rvalid <= 1'b0; axi.rresp <= 2'b00; axi.rdata <= '0;
        end else begin
            if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
            if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
            if ((aw_got || (axi.awvalid && axi.awready)) &&
                (w_got  || (axi.wvalid  && axi.wready))) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                axi.bresp <= cfg_bresp;
                if (cfg_bdly == 0) axi.bvalid <= 1'b1;
                else begin b_pend <= 1'b1; b_tmr <= cfg_bdly; end
            end else begin
                if (axi.awvalid && axi.awready) aw_got <= 1'b1;
                if (axi.wvalid  && axi.wready)  w_got  <= 1'b1;
            end
            if (b_pend) begin
                if (b_tmr <= 1) begin axi.bvalid <= 1'b1; b_pend <= 1'b0; end
                else b_tmr <= b_tmr - 1;
            end
            if (axi.arvalid && axi.arready) begin
                axi.rresp <= cfg_rresp;
                axi.rdata <= cfg_rdata;
                if (cfg_rdly == 0) axi.rvalid <= 1'b1;
                else begin r_pend <= 1'b1; r_tmr <= cfg_rdly; end
            end
            if (r_pend) begin
                if (r_tmr <= 1) begin axi.rvalid <= 1'b1; r_pend <= 1'b0; end
                else r_tmr <= r_tmr - 1;
            end
        end
    end

    // ---------------- bus monitor and protocol rules ----------------
    int cyc = 0, aw_cnt = 0, w_cnt = 0, ar_cnt = 0, vo_cnt = 0, viol = 0, aw_cyc = 0;
    int mon_v;
    logic [63:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
    logic [7:0]  cap_wstrb = '0;
    logic        p_awv, p_awhs, p_wv, p_whs, p_arv, p_arhs, p_vo;
    logic [63:0] p_awaddr, p_wdata, p_araddr;
    logic [7:0]  p_wstrb;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_awv <= 1'b0; p_awhs <= 1'b0; p_wv <= 1'b0; p_whs <= 1'b0;
            p_arv <= 1'b0; p_arhs <= 1'b0; p_vo <= 1'b0;
            p_awaddr <= '0; p_wdata <= '0; p_araddr <= '0; p_wstrb <= '0;
        end else begin
            mon_v = 0;
            if (p_awv && !p_awhs && (!axi.awvalid || axi.awaddr != p_awaddr)) mon_v++;
            if (p_wv && !p_whs && (!axi.wvalid || axi.wdata != p_wdata || axi.wstrb != p_wstrb)) mon_v++;
            if (p_arv && !p_arhs && (!axi.arvalid || axi.araddr != p_araddr)) mon_v++;
            if (axi.awvalid && axi.awprot != 3'b000) mon_v++;
            if (axi.arvalid && axi.arprot != 3'b000) mon_v++;
            if (p_vo && valid_o) mon_v++;
            viol <= viol + mon_v;

            p_awv <= axi.awvalid; p_awhs <= axi.awvalid && axi.awready; p_awaddr <= axi.awaddr;
            p_wv  <= axi.wvalid;  p_whs  <= axi.wvalid && axi.wready;
            p_wdata <= axi.wdata; p_wstrb <= axi.wstrb;
            p_arv <= axi.arvalid; p_arhs <= axi.arvalid && axi.arready; p_araddr <= axi.araddr;
            p_vo  <= valid_o;

            if (axi.awvalid && axi.awready) begin
                aw_cnt <= aw_cnt + 1; aw_cyc <= cyc; cap_awaddr <= axi.awaddr;
            end
            if (axi.wvalid && axi.wready) begin
                w_cnt <= w_cnt + 1; cap_wdata <= axi.wdata; cap_wstrb <= axi.wstrb;
            end
            if (axi.arvalid && axi.arready) begin
                ar_cnt <= ar_cnt + 1; cap_araddr <= axi.araddr;
            end
            if (valid_o) vo_cnt <= vo_cnt + 1;
        end
        cyc <= cyc + 1;
    end

    // ---------------- checking helpers ----------------
    int n_pass = 0, n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic run_txn(input bit w, input bit r, input logic [63:0] a,
                           input logic [63:0] d, input logic [7:0] m, input bit scramble,
                           output int lat, output bit ok, output logic err,
                           output logic [63:0] rd, output int t0);
        @(negedge clk);
        wen_i = w; ren_i = r; addr_i = a; wdata_i = d; wmask_i = m;
        t0 = cyc;
        lat = 0; ok = 1'b0; err = 1'b0; rd = '0;
        while (!ok && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (valid_o) begin
                ok = 1'b1; err = resp_err_o; rd = rdata_o;
            end else if (scramble) begin
                addr_i  = {$urandom, $urandom};
                wdata_i = {$urandom, $urandom};
                wmask_i = 8'($urandom);
            end
        end
        wen_i = 1'b0; ren_i = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          wen;
        bit          ren;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  mask;
        logic [1:0]  resp;
        logic [63:0] slv_rdata;
        bit          exp_wr;
        bit          exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int          lat, t0, aw0, w0, ar0, vo0, guard;
        bit          ok;
        logic        err;
        logic [63:0] rd, m_rdata;

        vecs[0] = '{1'b1, 1'b0, 64'h8000_0000, 64'h1122_3344_5566_7788, 8'hFF, 2'b00, 64'h0,
                    1'b1, 1'b0, 64'h0};
        vecs[1] = '{1'b0, 1'b1, 64'h1000, 64'h0, 8'h00, 2'b00, 64'hDEAD_BEEF,
                    1'b0, 1'b0, 64'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b0, 64'h20, 64'hAAAA, 8'h0F, 2'b00, 64'h9999,
                    1'b1, 1'b0, 64'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b1, 64'h40, 64'h77, 8'hF0, 2'b10, 64'h1111,
                    1'b1, 1'b1, 64'hDEAD_BEEF};
        vecs[4] = '{1'b0, 1'b1, 64'h2000, 64'h0, 8'h00, 2'b10, 64'h0123_4567_89AB_CDEF,
                    1'b0, 1'b1, 64'h0123_4567_89AB_CDEF};
        vecs[5] = '{1'b0, 1'b1, 64'h3000, 64'h0, 8'h00, 2'b00, 64'h55,
                    1'b0, 1'b0, 64'h55};

        rstn = 1'b0; wen_i = 1'b0; ren_i = 1'b0;
        addr_i = '0; wdata_i = '0; wmask_i = '0;
        repeat (3) @(negedge clk);
        chk("reset_valid_o",  {63'd0, valid_o}, 64'd0);
        chk("reset_err",      {63'd0, resp_err_o}, 64'd0);
        chk("reset_rdata",    rdata_o, 64'd0);
        chk("reset_axi_valids", {59'd0, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 64'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vectors with an always-ready slave.
        for (int i = 0; i < 6; i++) begin
            cfg_bresp = vecs[i].resp; cfg_rresp = vecs[i].resp;
            cfg_rdata = vecs[i].slv_rdata; cfg_bdly = 0; cfg_rdly = 0;
            aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt;
            run_txn(vecs[i].wen, vecs[i].ren, vecs[i].addr, vecs[i].wdata, vecs[i].mask,
                    1'b0, lat, ok, err, rd, t0);
            chk($sformatf("v%0d_done", i),    {63'd0, ok}, 64'd1);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd3);
            chk($sformatf("v%0d_err", i),     {63'd0, err}, {63'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_rdata", i),   rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d_aw_hs", i),   64'(aw_cnt - aw0), vecs[i].exp_wr ? 64'd1 : 64'd0);
            chk($sformatf("v%0d_w_hs", i),    64'(w_cnt - w0),   vecs[i].exp_wr ? 64'd1 : 64'd0);
            chk($sformatf("v%0d_ar_hs", i),   64'(ar_cnt - ar0), vecs[i].exp_wr ? 64'd0 : 64'd1);
            if (vecs[i].exp_wr) begin
                chk($sformatf("v%0d_awaddr", i), cap_awaddr, vecs[i].addr);
                chk($sformatf("v%0d_wdata", i),  cap_wdata,  vecs[i].wdata);
                chk($sformatf("v%0d_wstrb", i),  {56'd0, cap_wstrb}, {56'd0, vecs[i].mask});
                chk($sformatf("v%0d_aw_cycle", i), 64'(aw_cyc - t0), 64'd1);
            end else begin
                chk($sformatf("v%0d_araddr", i), cap_araddr, vecs[i].addr);
            end
`ifdef AXI_MASTER_DEBUG_EN
            if (i == 2) begin
                chk("debug_txn_cnt", {32'd0, debug_cnt}, 64'd3);
                chk("debug_state_idle", {61'd0, debug_state}, 64'd0);
            end
`endif
        end

        // Write with W accepted several cycles after AW; request inputs changed mid-flight.
        force_aw = 1'b1; force_w = 1'b0; cfg_bresp = 2'b00; cfg_bdly = 0;
        aw0 = aw_cnt; w0 = w_cnt; vo0 = vo_cnt;
        @(negedge clk);
        wen_i = 1'b1; addr_i = 64'h7000; wdata_i = 64'hA5A5_5A5A_0F0F_F0F0; wmask_i = 8'h3C;
        @(negedge clk);
        chk("split_both_valid", {62'd0, axi.awvalid, axi.wvalid}, 64'd3);
        addr_i = 64'hBAD; wdata_i = 64'hBAD; wmask_i = 8'h01;
        @(negedge clk);
        chk("split_aw_dropped_w_held", {62'd0, axi.awvalid, axi.wvalid}, 64'd1);
        chk("split_wdata_stable", axi.wdata, 64'hA5A5_5A5A_0F0F_F0F0);
        repeat (3) @(negedge clk);
        force_w = 1'b1;
        guard = 0;
        while (!valid_o && guard < 50) begin @(posedge clk); #1; guard++; end
        chk("split_done", {63'd0, valid_o}, 64'd1);
        wen_i = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("split_aw_hs", 64'(aw_cnt - aw0), 64'd1);
        chk("split_w_hs",  64'(w_cnt - w0),   64'd1);
        chk("split_wdata", cap_wdata, 64'hA5A5_5A5A_0F0F_F0F0);
        chk("split_wstrb", {56'd0, cap_wstrb}, 64'h3C);
        chk("split_awaddr", cap_awaddr, 64'h7000);
        chk("split_one_valid", 64'(vo_cnt - vo0), 64'd1);

        // Reset while waiting for read data.
        cfg_rdly = 20; cfg_rdata = 64'h1234; cfg_rresp = 2'b00;
        @(negedge clk);
        ren_i = 1'b1; addr_i = 64'h5000;
        guard = 0;
        while (!axi.rready && guard < 10) begin @(negedge clk); guard++; end
        chk("rst_reached_rresp", {63'd0, axi.rready}, 64'd1);
        vo0 = vo_cnt;
        rstn = 1'b0;
        #1;
        chk("rst_axi_valids", {59'd0, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 64'd0);
        chk("rst_valid_o", {63'd0, valid_o}, 64'd0);
        chk("rst_rdata", rdata_o, 64'd0);
        chk("rst_err", {63'd0, resp_err_o}, 64'd0);
        ren_i = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (25) @(negedge clk);
        chk("rst_no_valid", 64'(vo_cnt - vo0), 64'd0);
        cfg_rdly = 0; cfg_rdata = 64'hCAFE_F00D;
        run_txn(1'b0, 1'b1, 64'h6000, 64'h0, 8'h00, 1'b0, lat, ok, err, rd, t0);
        chk("post_rst_done", {63'd0, ok}, 64'd1);
        chk("post_rst_rdata", rd, 64'hCAFE_F00D);
        chk("post_rst_err", {63'd0, err}, 64'd0);
        m_rdata = 64'hCAFE_F00D;

        // Randomized transactions against the behavioural model.
        rand_mode = 1'b1;
        for (int n = 0; n < 40; n++) begin
            bit w, r;
            logic [63:0] a, d, sd;
            logic [7:0]  m;
            logic [1:0]  resp;
            w = 1'($urandom % 2); r = 1'($urandom % 2);
            if (!w && !r) r = 1'b1;
            a = {$urandom, $urandom}; d = {$urandom, $urandom}; sd = {$urandom, $urandom};
            m = 8'($urandom); resp = 2'($urandom % 4);
            cfg_bresp = resp; cfg_rresp = resp; cfg_rdata = sd;
            cfg_bdly = int'($urandom % 4); cfg_rdly = int'($urandom % 4);
            if (!w) m_rdata = sd;
            aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt;
            run_txn(w, r, a, d, m, 1'b1, lat, ok, err, rd, t0);
            chk($sformatf("rnd%0d_done", n),  {63'd0, ok}, 64'd1);
            chk($sformatf("rnd%0d_err", n),   {63'd0, err}, {63'd0, (resp != 2'b00)});
            chk($sformatf("rnd%0d_rdata", n), rd, m_rdata);
            chk($sformatf("rnd%0d_ar_hs", n), 64'(ar_cnt - ar0), w ? 64'd0 : 64'd1);
            chk($sformatf("rnd%0d_aw_hs", n), 64'(aw_cnt - aw0), w ? 64'd1 : 64'd0);
            if (w) begin
                chk($sformatf("rnd%0d_w_hs", n),  64'(w_cnt - w0), 64'd1);
                chk($sformatf("rnd%0d_awaddr", n), cap_awaddr, a);
                chk($sformatf("rnd%0d_wdata", n),  cap_wdata, d);
                chk($sformatf("rnd%0d_wstrb", n),  {56'd0, cap_wstrb}, {56'd0, m});
            end else begin
                chk($sformatf("rnd%0d_araddr", n), cap_araddr, a);
            end
        end
        rand_mode = 1'b0;

        repeat (2) @(negedge clk);
        chk("protocol_violations", 64'(viol), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
